// File: rtl/sram_slot_scheduler.sv
// Time-slotted VRAM SRAM scheduler: one GPU slot per 4-cycle period in active video, CPU write/read elsewhere.
// Define SRAM_SCHED_STATS_EN to add op counters and the worst-case CPU read wait.
module sram_slot_scheduler #(
   parameter int ADDR_W    = 17,
   parameter int GPU_PHASE = 0
) (
   input  logic              clk100,
   input  logic              reset,
   input  logic              phase_sync,
   input  logic              blank,
   input  logic [ADDR_W-1:0] gpu_addr,
   output logic [7:0]        gpu_data,
   input  logic              wr_fifo_empty,
   output logic              wr_fifo_rd_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [7:0]        rd_data,
   output logic [18:0]       sram_addr,
   output logic [7:0]        sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_dq_in,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_cs_n
`ifdef SRAM_SCHED_STATS_EN
   ,
   output logic [15:0]       stat_wr_cnt,
   output logic [15:0]       stat_rd_cnt,
   output logic [7:0]        stat_rd_wait_max
`endif
);

   typedef enum logic [1:0] {
      OP_IDLE,
      OP_GPU,
      OP_WRITE,
      OP_READ
   } op_t;

   localparam logic [1:0] GPU_SLOT = 2'(GPU_PHASE);

   op_t               op_p0;
   op_t               op_p1;
   logic [1:0]        phase;
   logic [1:0]        phase_next;
   logic              wr_valid;
   logic              fetch_pend;
   logic              last_grant_wr;
   logic              rd_pending;
   logic [ADDR_W-1:0] hold_addr;
   logic [7:0]        hold_data;

   assign sram_cs_n = 1'b0;

   always_comb begin
      phase_next = phase_sync ? 2'd0 : phase + 2'd1;
   end

   // A read already on the bus or being acked must not be issued a second time.
   always_comb begin
      rd_pending = rd_req && !rd_ack && (op_p1 != OP_READ);
   end

   always_comb begin
      wr_fifo_rd_en = !reset && !wr_valid && !fetch_pend && !wr_fifo_empty;
   end

   // Slot decision for the next bus cycle
   always_comb begin
      op_p0 = OP_GPU;
      if (blank || (phase_next != GPU_SLOT)) begin
         if (wr_valid && rd_pending) begin
            op_p0 = last_grant_wr ? OP_READ : OP_WRITE;
         end else if (wr_valid) begin
            op_p0 = OP_WRITE;
         end else if (rd_pending) begin
            op_p0 = OP_READ;
         end else begin
            op_p0 = OP_GPU;
         end
      end
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         op_p1 <= OP_IDLE;
      end else begin
         op_p1 <= op_p0;
      end
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         phase         <= 2'd0;
         wr_valid      <= 1'b0;
         fetch_pend    <= 1'b0;
         last_grant_wr <= 1'b0;
      end else begin
         phase <= phase_next;
         if (fetch_pend) begin
            wr_valid   <= 1'b1;
            fetch_pend <= 1'b0;
         end else if (op_p0 == OP_WRITE) begin
            wr_valid <= 1'b0;
         end
         if (wr_fifo_rd_en) begin
            fetch_pend <= 1'b1;
         end
         if (op_p0 == OP_WRITE) begin
            last_grant_wr <= 1'b1;
         end else if (op_p0 == OP_READ) begin
            last_grant_wr <= 1'b0;
         end
      end
   end

   // FIFO output is valid the cycle after the pop
   always_ff @(posedge clk100) begin
      if (fetch_pend) begin
         hold_addr <= wr_addr;
         hold_data <= wr_data;
      end
   end

   // Bus stage: pins registered from the slot decision
   always_ff @(posedge clk100) begin
      if (reset) begin
         sram_addr   <= 19'd0;
         sram_dq_out <= 8'd0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         case (op_p0)
            OP_WRITE: begin
               sram_addr   <= 19'(hold_addr);
               sram_dq_out <= hold_data;
               sram_dq_oe  <= 1'b1;
               sram_we_n   <= 1'b0;
               sram_oe_n   <= 1'b1;
            end
            OP_READ: begin
               sram_addr  <= 19'(rd_addr);
               sram_dq_oe <= 1'b0;
               sram_we_n  <= 1'b1;
               sram_oe_n  <= 1'b0;
            end
            default: begin
               sram_addr  <= 19'(gpu_addr);
               sram_dq_oe <= 1'b0;
               sram_we_n  <= 1'b1;
               sram_oe_n  <= 1'b0;
            end
         endcase
      end
   end

   // Capture stage: read data lands on the edge ending the bus cycle
   always_ff @(posedge clk100) begin
      if (reset) begin
         gpu_data <= 8'd0;
         rd_data  <= 8'd0;
         rd_ack   <= 1'b0;
      end else begin
         rd_ack <= (op_p1 == OP_READ);
         if (op_p1 == OP_GPU) begin
            gpu_data <= sram_dq_in;
         end
         if (op_p1 == OP_READ) begin
            rd_data <= sram_dq_in;
         end
      end
   end

`ifdef SRAM_SCHED_STATS_EN
   logic [7:0] rd_wait;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk100) begin
      if (reset) begin
         stat_wr_cnt      <= 16'd0;
         stat_rd_cnt      <= 16'd0;
         stat_rd_wait_max <= 8'd0;
         rd_wait          <= 8'd0;
      end else begin
         if (op_p1 == OP_WRITE) begin
            stat_wr_cnt <= stat_wr_cnt + 16'd1;
         end
         if (rd_ack) begin
            stat_rd_cnt <= stat_rd_cnt + 16'd1;
            if (rd_wait > stat_rd_wait_max) begin
               stat_rd_wait_max <= rd_wait;
            end
            rd_wait <= 8'd0;
         end else if (rd_req) begin
            rd_wait <= sat_inc8(rd_wait);
         end else begin
            rd_wait <= 8'd0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_slot_scheduler.sv
// Scoreboard bench for sram_slot_scheduler: SRAM/FIFO models, expected writes and reads queued at issue time.
module tb_sram_slot_scheduler;

   typedef struct packed {
      logic [16:0] addr;
      logic [7:0]  data;
   } wr_ent_t;

   logic        clk100 = 1'b0;
   logic        reset;
   logic        phase_sync;
   logic        blank;
   logic [16:0] gpu_addr;
   logic [7:0]  gpu_data;
   logic        wr_fifo_empty;
   logic        wr_fifo_rd_en;
   logic [16:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rd_req;
   logic [16:0] rd_addr;
   logic        rd_ack;
   logic [7:0]  rd_data;
   logic [18:0] sram_addr;
   logic [7:0]  sram_dq_out;
   logic        sram_dq_oe;
   logic [7:0]  sram_dq_in;
   logic        sram_we_n;
   logic        sram_oe_n;
   logic        sram_cs_n;
`ifdef SRAM_SCHED_STATS_EN
   logic [15:0] stat_wr_cnt;
   logic [15:0] stat_rd_cnt;
   logic [7:0]  stat_rd_wait_max;
`endif

   logic [7:0]  mem [0:131071];
   wr_ent_t     fifo_q[$];
   wr_ent_t     exp_wr_q[$];
   logic [7:0]  exp_rd_q[$];
   int          total = 0;
   int          bad = 0;
   logic        done = 1'b0;
   logic        prime_expect = 1'b0;
   logic        psync_irregular = 1'b0;
   logic        t6_timeout = 1'b0;
   int          rd_wait = 0;

   sram_slot_scheduler #(.ADDR_W(17), .GPU_PHASE(0)) dut (
      .clk100(clk100), .reset(reset), .phase_sync(phase_sync), .blank(blank),
      .gpu_addr(gpu_addr), .gpu_data(gpu_data),
      .wr_fifo_empty(wr_fifo_empty), .wr_fifo_rd_en(wr_fifo_rd_en),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
      .sram_cs_n(sram_cs_n)
`ifdef SRAM_SCHED_STATS_EN
      , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
      .stat_rd_wait_max(stat_rd_wait_max)
`endif
   );

   always #5 clk100 = ~clk100;

   assign sram_dq_in = mem[sram_addr[16:0]];

   task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // FIFO model: a pop sampled in one cycle shows its head on the next cycle
   initial begin : fifo_model
      logic    pop;
      wr_ent_t e;
      wr_fifo_empty = 1'b1;
      wr_addr = '0;
      wr_data = '0;
      forever begin
         @(negedge clk100);
         pop = wr_fifo_rd_en;
         @(posedge clk100);
         #1;
         if (reset) begin
            fifo_q.delete();
         end else if (pop && fifo_q.size() != 0) begin
            e = fifo_q.pop_front();
            wr_addr = e.addr;
            wr_data = e.data;
         end
         wr_fifo_empty = (fifo_q.size() == 0);
      end
   end

   initial begin : psync_gen
      int n;
      n = 0;
      phase_sync = 1'b0;
      forever begin
         @(negedge clk100);
         if (psync_irregular) phase_sync = ($urandom_range(0, 5) == 0);
         else phase_sync = (n % 4 == 3);
         n++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : monitor
      logic [1:0]  ph;
      logic        gslot;
      logic        prev_gpu;
      logic [16:0] prev_addr;
      logic        rd_prev;
      int          rd_start;
      int          cyc;
      wr_ent_t     we;
      logic [7:0]  er;
      ph = 2'd0; prev_gpu = 1'b0; prev_addr = '0; rd_prev = 1'b0; rd_start = 0; cyc = 0;
      while (!done) begin
         @(posedge clk100);
         #2;
         cyc++;
         if (reset) begin
            check("reset_vals",
                  {gpu_data, rd_data, rd_ack, wr_fifo_rd_en, sram_addr, sram_dq_out,
                   sram_dq_oe, sram_we_n, sram_oe_n, sram_cs_n} ==
                  {8'h0, 8'h0, 1'b0, 1'b0, 19'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0},
                  64'({gpu_data, rd_data, rd_ack, wr_fifo_rd_en, sram_addr, sram_dq_out,
                       sram_dq_oe, sram_we_n, sram_oe_n, sram_cs_n}),
                  64'({8'h0, 8'h0, 1'b0, 1'b0, 19'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0}));
            ph = 2'd0;
            prev_gpu = 1'b0;
            rd_prev = 1'b0;
            exp_wr_q.delete();
            exp_rd_q.delete();
            continue;
         end
         ph = phase_sync ? 2'd0 : ph + 2'd1;
         gslot = !blank && (ph == 2'd0);
         if (gslot)
            check("gpu_slot_op", {sram_oe_n, sram_we_n, sram_dq_oe, sram_addr} == {1'b0, 1'b1, 1'b0, 19'(gpu_addr)},
                  64'({sram_oe_n, sram_we_n, sram_dq_oe, sram_addr}), 64'({1'b0, 1'b1, 1'b0, 19'(gpu_addr)}));
         if (prev_gpu)
            check("gpu_data", gpu_data == mem[prev_addr], 64'(gpu_data), 64'(mem[prev_addr]));
         if (!sram_oe_n)
            check("turnaround_dq_oe", sram_dq_oe == 1'b0, 64'(sram_dq_oe), 64'd0);
         if (!sram_we_n) begin
            check("write_expected", exp_wr_q.size() != 0, 64'(sram_addr), 64'd0);
            if (exp_wr_q.size() != 0) begin
               we = exp_wr_q.pop_front();
               check("wr_addr", sram_addr == 19'(we.addr), 64'(sram_addr), 64'(we.addr));
               check("wr_data", sram_dq_out == we.data, 64'(sram_dq_out), 64'(we.data));
               check("wr_ctrl", {sram_dq_oe, sram_oe_n} == 2'b11, 64'({sram_dq_oe, sram_oe_n}), 64'd3);
               check("wr_not_gpu_slot", !gslot, 64'(ph), 64'd1);
            end
         end
         if (rd_req && !rd_prev) rd_start = cyc;
         rd_prev = rd_req;
         if (rd_ack) begin
            check("ack_expected", exp_rd_q.size() != 0, 64'(rd_data), 64'd0);
            if (exp_rd_q.size() != 0) begin
               er = exp_rd_q.pop_front();
               check("rd_data", rd_data == er, 64'(rd_data), 64'(er));
               if (!psync_irregular)
                  check("rd_latency", (cyc - rd_start) <= 7, 64'(cyc - rd_start), 64'd7);
            end
         end
         if (prime_expect)
            check("prime_op", !sram_oe_n && !sram_dq_oe && sram_addr == 19'(gpu_addr),
                  64'({sram_oe_n, sram_addr}), 64'({1'b0, 19'(gpu_addr)}));
         prev_gpu = !sram_oe_n && (sram_addr < 19'h100);
         prev_addr = sram_addr[16:0];
      end
      check("wr_queue_drained", exp_wr_q.size() == 0, 64'(exp_wr_q.size()), 64'd0);
      check("rd_queue_drained", exp_rd_q.size() == 0, 64'(exp_rd_q.size()), 64'd0);
      check("t6_rd_en_seen", !t6_timeout, 64'(t6_timeout), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic tick();
      @(negedge clk100);
      if (rd_req && rd_ack) begin
         rd_req = 1'b0;
      end else if (rd_req) begin
         rd_wait++;
         if (rd_wait > 20) rd_req = 1'b0;
      end
   endtask

   task automatic push_wr(input logic [16:0] a, input logic [7:0] d);
      wr_ent_t e;
      e.addr = a;
      e.data = d;
      fifo_q.push_back(e);
      exp_wr_q.push_back(e);
   endtask

   task automatic start_read(input logic [16:0] a);
      rd_addr = a;
      rd_req = 1'b1;
      rd_wait = 0;
      exp_rd_q.push_back(mem[a]);
   endtask

   task automatic wait_drain(input int n);
      for (int i = 0; i < n && (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || rd_req); i++) tick();
      tick();
   endtask

   initial begin : stimulus
      int w;
      for (int i = 0; i < 131072; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      mem[17'h00010] = 8'hA5;
      mem[17'h00200] = 8'h3E;
      reset = 1'b1; blank = 1'b0; rd_req = 1'b0; rd_addr = '0; gpu_addr = 17'h00010;
      repeat (3) tick();
      reset = 1'b0;
      // active video, idle CPU
      repeat (16) tick();
      // single write
      push_wr(17'h00123, 8'h5C);
      wait_drain(40);
      // writes plus a read competing for CPU slots
      for (int i = 0; i < 4; i++) push_wr(17'h01000 + 17'(i), 8'($urandom));
      start_read(17'h00200);
      wait_drain(60);
      // blanking with nothing pending primes every slot
      blank = 1'b1;
      repeat (2) tick();
      prime_expect = 1'b1;
      repeat (8) tick();
      prime_expect = 1'b0;
      // blank falling while writes are in flight
      for (int k = 0; k < 12; k++) begin
         blank = 1'b1;
         for (int i = 0; i < 3; i++) push_wr(17'h01100 + 17'($urandom_range(0, 255)), 8'($urandom));
         repeat ($urandom_range(2, 7)) tick();
         blank = 1'b0;
         repeat (14) tick();
      end
      wait_drain(60);
      // random traffic, irregular then regular phase_sync
      for (int i = 0; i < 500; i++) begin
         tick();
         psync_irregular = (i < 200);
         if ($urandom_range(0, 9) == 0) blank = ~blank;
         if ($urandom_range(0, 3) == 0) gpu_addr = 17'($urandom_range(0, 255));
         if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0)
            push_wr(17'h01000 + 17'($urandom_range(0, 4095)), 8'($urandom));
         if (!rd_req && !rd_ack && $urandom_range(0, 4) == 0)
            start_read(17'h00200 + 17'($urandom_range(0, 255)));
      end
      psync_irregular = 1'b0;
      blank = 1'b0;
      wait_drain(100);
      // reset right after a FIFO pop drops the pending write
      push_wr(17'h01ABC, 8'h77);
      w = 0;
      while (!wr_fifo_rd_en && w < 10) begin
         tick();
         w++;
      end
      if (w >= 10) t6_timeout = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      repeat (20) tick();
      done = 1'b1;
   end

endmodule
